half_op_sequencer: RTL

Byte-serial command sequencer for the FP16 (half-precision) arithmetic unit inside `tt_um_half`. It accepts an opcode byte and operand bytes over a valid/ready byte stream and launches one operation on the FP16 unit. It waits for completion, with a timeout, then streams back the result and a status byte. It sits between the top-level pin adapter and the FP16 datapath, and is the only block that drives the datapath's start and operand inputs.

---
 rtl/half_pkg.sv | 40 ++++
 rtl/half_op_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/half_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : half_pkg
//  Description : Shared types and constants for the FP16 command sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package half_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_SQRT = 3'd4,
        OP_ABS  = 3'd5
    } half_op_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LD_A0 = 4'd1,
        ST_LD_A1 = 4'd2,
        ST_LD_B0 = 4'd3,
        ST_LD_B1 = 4'd4,
        ST_EXEC  = 4'd5,
        ST_WAIT  = 4'd6,
        ST_RESP0 = 4'd7,
        ST_RESP1 = 4'd8,
        ST_RESP2 = 4'd9
    } seq_state_e;

    localparam logic [15:0] HALF_QNAN        = 16'h7E00;
    localparam int          STAT_BAD_OP_BIT  = 7;
    localparam int          STAT_TIMEOUT_BIT = 6;

    function automatic logic op_is_unary(input half_op_e op);
        return (op == OP_SQRT) || (op == OP_ABS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/half_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : half_op_sequencer
//  Description : Byte-serial command front end for the FP16 unit: collects an
//                opcode and operands, launches one op, returns result+status.
//  Revision    : 1.0  initial release
// ============================================================================
module half_op_sequencer
    import half_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        fpu_start,
    output logic [2:0]  fpu_op,
    output logic [15:0] fpu_a,
    output logic [15:0] fpu_b,
    input  logic        fpu_done,
    input  logic [15:0] fpu_result,
    input  logic [4:0]  fpu_flags
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    seq_state_e  state_q,  state_d;
    half_op_e    op_q,     op_d;
    logic [15:0] a_q,      a_d;
    logic [15:0] b_q,      b_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  cnt_q,    cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            result_q <= 16'h0000;
            status_q <= 8'h00;
            cnt_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        status_d = status_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: if (in_valid) begin
                if (in_data[2:0] > 3'd5) begin
                    result_d                  = HALF_QNAN;
                    status_d                  = 8'h00;
                    status_d[STAT_BAD_OP_BIT] = 1'b1;
                    state_d                   = ST_RESP0;
                end else begin
                    op_d    = half_op_e'(in_data[2:0]);
                    b_d     = 16'h0000;  // unary ops present a zero B operand
                    state_d = ST_LD_A0;
                end
            end
            ST_LD_A0: if (in_valid) begin
                a_d[7:0] = in_data;
                state_d  = ST_LD_A1;
            end
            ST_LD_A1: if (in_valid) begin
                a_d[15:8] = in_data;
                state_d   = op_is_unary(op_q) ? ST_EXEC : ST_LD_B0;
            end
            ST_LD_B0: if (in_valid) begin
                b_d[7:0] = in_data;
                state_d  = ST_LD_B1;
            end
            ST_LD_B1: if (in_valid) begin
                b_d[15:8] = in_data;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                cnt_d   = 8'h00;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // done takes priority over a coincident timeout
                if (fpu_done) begin
                    result_d = fpu_result;
                    status_d = {3'b000, fpu_flags};
                    state_d  = ST_RESP0;
                end else if (cnt_q == CNT_LAST) begin
                    result_d                   = HALF_QNAN;
                    status_d                   = 8'h00;
                    status_d[STAT_TIMEOUT_BIT] = 1'b1;
                    state_d                    = ST_RESP0;
                end
            end
            ST_RESP0: if (out_ready) state_d = ST_RESP1;
            ST_RESP1: if (out_ready) state_d = ST_RESP2;
            ST_RESP2: if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        unique case (state_q)
            ST_RESP0: out_data = result_q[7:0];
            ST_RESP1: out_data = result_q[15:8];
            ST_RESP2: out_data = status_q;
            default:  out_data = 8'h00;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE)  || (state_q == ST_LD_A0) ||
                       (state_q == ST_LD_A1) || (state_q == ST_LD_B0) ||
                       (state_q == ST_LD_B1);
    assign out_valid = (state_q == ST_RESP0) || (state_q == ST_RESP1) ||
                       (state_q == ST_RESP2);
    assign busy      = (state_q != ST_IDLE);
    assign fpu_start = (state_q == ST_EXEC);
    assign fpu_op    = op_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;

endmodule
`default_nettype wire
